fetch_queue_stage: RTL

- Parametrised successor to the single-register fetch stage of the MIPS pipeline CPU.
- Holds the PC and drives the instruction-memory address.
- Buffers fetched {PC, instr} pairs in a QDEPTH-entry FIFO, which replaces the single IF/ID register, with a valid/ready handshake toward D.
- Branch/jump redirects from D flush the queue and reload the PC.

---
 rtl/fetch_queue_stage_if.sv | 37 +++
 rtl/fetch_queue_stage.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage_if.sv
// Fetch-queue stage bus: instruction-memory port, redirect input and D handshake.
// master = fetch_queue_stage, slave = decode side / instruction memory.
interface fetch_queue_stage_if;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        D_ready;
    logic        D_valid;
    logic [31:0] D_instr;
    logic [31:0] D_PC;
    logic        D_exc;

    modport master (
        output im_addr,
        input  im_rdata,
        input  redirect_valid,
        input  redirect_pc,
        input  D_ready,
        output D_valid,
        output D_instr,
        output D_PC,
        output D_exc
    );

    modport slave (
        input  im_addr,
        output im_rdata,
        output redirect_valid,
        output redirect_pc,
        output D_ready,
        input  D_valid,
        input  D_instr,
        input  D_PC,
        input  D_exc
    );
endinterface

// File: rtl/fetch_queue_stage.sv
// PC register plus QDEPTH-entry {PC, instr} fetch FIFO feeding decode.
// Optional macro FETCH_EXC_EN: fetch range/alignment check, exc bit, halt.
module fetch_queue_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          QDEPTH   = 4,
    parameter int          IM_WORDS = 4096
) (
    input logic                 clk,
    input logic                 Reset,
    input logic                 Enable,
    fetch_queue_stage_if.master fq
);
    localparam int            AW   = $clog2(QDEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(QDEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0]   pc_mem    [QDEPTH];
    logic [31:0]   instr_mem [QDEPTH];

    logic          d_valid;
    logic          pop;
    logic          push;
    logic          halt;
    logic          fault;
    logic [31:0]   redir_tgt;
    logic [31:0]   push_instr;

`ifdef FETCH_EXC_EN
    localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + 33'(4 * IM_WORDS);

    logic              halt_q, halt_d;
    logic [QDEPTH-1:0] exc_q;

    // Raw target: a misaligned redirect is caught by the fetch check instead.
    assign redir_tgt = fq.redirect_pc;
    assign halt      = halt_q;
    assign fault     = (pc_q[1:0] != 2'b00)
                     || (pc_q < PC_RESET)
                     || ({1'b0, pc_q} >= PC_LIMIT);
    assign fq.D_exc  = d_valid & exc_q[head_q];

    // Halt: set by a faulting push, cleared by redirect.
    always_comb begin
        halt_d = halt_q;
        if (Enable) begin
            if (fq.redirect_valid)
                halt_d = 1'b0;
            else if (push && fault)
                halt_d = 1'b1;
        end
    end

    // Halt register.
    always_ff @(posedge clk) begin
        if (Reset)
            halt_q <= 1'b0;
        else
            halt_q <= halt_d;
    end

    // Exception bit storage alongside the queue payload.
    always_ff @(posedge clk) begin
        if (!Reset && Enable && push)
            exc_q[tail_q] <= fault;
    end
`else
    assign redir_tgt = fq.redirect_pc & 32'hFFFF_FFFC;
    assign halt      = 1'b0;
    assign fault     = 1'b0;
    assign fq.D_exc  = 1'b0;
`endif

    assign push_instr = fault ? 32'h0 : fq.im_rdata;

    assign d_valid = (count_q != '0);
    assign pop     = d_valid & fq.D_ready & ~fq.redirect_valid;
    assign push    = ~fq.redirect_valid & ~halt
                   & ((count_q != FULL) | pop);

    assign fq.im_addr = pc_q;
    assign fq.D_valid = d_valid;
    assign fq.D_instr = d_valid ? instr_mem[head_q] : 32'h0;
    assign fq.D_PC    = d_valid ? pc_mem[head_q]    : 32'h0;

    // Next state: redirect wins, otherwise independent push and pop.
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (Enable) begin
            if (fq.redirect_valid) begin
                pc_d    = redir_tgt;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) begin
                    tail_d = tail_q + AW'(1);
                    pc_d   = pc_q + 32'd4;
                end
                if (pop)
                    head_d = head_q + AW'(1);
                if (push && !pop)
                    count_d = count_q + (AW+1)'(1);
                else if (pop && !push)
                    count_d = count_q - (AW+1)'(1);
            end
        end
    end

    // PC, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (Reset) begin
            pc_q    <= PC_RESET;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue payload; empty slots are masked on the output, so no reset.
    always_ff @(posedge clk) begin
        if (!Reset && Enable && push) begin
            pc_mem[tail_q]    <= pc_q;
            instr_mem[tail_q] <= push_instr;
        end
    end
endmodule
